// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types for the fetch/memory-stage port arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : which pipeline stage owns the access being issued
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACC_I, ACC_D, RESP} arb_state_t;
    typedef enum logic {OWN_F, OWN_D} owner_t;
endpackage

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch (F) and memory (M) stages.
// Ports:
//   CLK, nRESET                      clock (rising edge), async active-low reset
//   IReqF/IAddrF -> IRdataF/IReadyF  fetch read request and one-cycle completion
//   DReqM/DWeM/DAddrM/DWdataM        data request (read or write)
//   DRdataM/DReadyM                  data read result and one-cycle completion
//   MemReq/MemWe/MemAddr/MemWdata    registered memory request, held until MemAck
//   MemRdata/MemAck                  memory response
//   StallF/StallM                    combinational per-stage stall requests
//   ErrAck                           sticky flag: MemAck with no access outstanding
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int MAX_D_BURST = 4
) (
    input  logic          CLK,
    input  logic          nRESET,
    input  logic          IReqF,
    input  logic [AW-1:0] IAddrF,
    output logic [DW-1:0] IRdataF,
    output logic          IReadyF,
    input  logic          DReqM,
    input  logic          DWeM,
    input  logic [AW-1:0] DAddrM,
    input  logic [DW-1:0] DWdataM,
    output logic [DW-1:0] DRdataM,
    output logic          DReadyM,
    output logic          MemReq,
    output logic          MemWe,
    output logic [AW-1:0] MemAddr,
    output logic [DW-1:0] MemWdata,
    input  logic [DW-1:0] MemRdata,
    input  logic          MemAck,
    output logic          StallF,
    output logic          StallM,
    output logic          ErrAck
);
    localparam int CW = $clog2(MAX_D_BURST + 1);

    arb_state_t    state, stateN;
    logic [CW-1:0] dCnt, dCntN;
    logic          memReqN, memWeN, iReadyN, dReadyN, errAckN;
    logic [AW-1:0] memAddrN;
    logic [DW-1:0] memWdataN, iRdataN, dRdataN;
    logic          eligF, eligD, burstHit, grantD, grantF, inAcc;
    owner_t        owner;

    assign StallF = IReqF & ~IReadyF;
    assign StallM = DReqM & ~DReadyM;

    always_comb begin
        // A request seen alongside its own Ready belongs to the access just finished.
        eligF     = IReqF & ~IReadyF;
        eligD     = DReqM & ~DReadyM;
        burstHit  = eligF && dCnt == CW'(MAX_D_BURST);
        inAcc     = state == ACC_I || state == ACC_D;
        grantD    = ~inAcc & eligD & ~burstHit;
        grantF    = ~inAcc & eligF & ~grantD;
        owner     = grantD ? OWN_D : OWN_F;
        stateN    = state;
        dCntN     = dCnt;
        memReqN   = MemReq;
        memWeN    = MemWe;
        memAddrN  = MemAddr;
        memWdataN = MemWdata;
        iRdataN   = IRdataF;
        dRdataN   = DRdataM;
        iReadyN   = 1'b0;
        dReadyN   = 1'b0;
        errAckN   = ErrAck | (MemAck & ~inAcc);
        if (inAcc) begin
            if (MemAck) begin
                stateN  = RESP;
                memReqN = 1'b0;
                iReadyN = state == ACC_I;
                dReadyN = state == ACC_D;
                iRdataN = (!MemWe && state == ACC_I) ? MemRdata : IRdataF;
                dRdataN = (!MemWe && state == ACC_D) ? MemRdata : DRdataM;
            end
        end else if (grantD || grantF) begin
            stateN    = owner == OWN_D ? ACC_D : ACC_I;
            memReqN   = 1'b1;
            memWeN    = owner == OWN_D ? DWeM : 1'b0;
            memAddrN  = owner == OWN_D ? DAddrM : IAddrF;
            memWdataN = owner == OWN_D ? DWdataM : MemWdata;
            // Count M grants only while F is waiting, so the limit bounds F's wait.
            dCntN     = (owner == OWN_F || !IReqF) ? '0 :
                        (dCnt == CW'(MAX_D_BURST)) ? dCnt : dCnt + 1'b1;
        end else begin
            stateN = IDLE;
        end
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state    <= IDLE;
            dCnt     <= '0;
            MemReq   <= 1'b0;
            MemWe    <= 1'b0;
            MemAddr  <= '0;
            MemWdata <= '0;
            IRdataF  <= '0;
            DRdataM  <= '0;
            IReadyF  <= 1'b0;
            DReadyM  <= 1'b0;
            ErrAck   <= 1'b0;
        end else begin
            state    <= stateN;
            dCnt     <= dCntN;
            MemReq   <= memReqN;
            MemWe    <= memWeN;
            MemAddr  <= memAddrN;
            MemWdata <= memWdataN;
            IRdataF  <= iRdataN;
            DRdataM  <= dRdataN;
            IReadyF  <= iReadyN;
            DReadyM  <= dReadyN;
            ErrAck   <= errAckN;
        end
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one shared single-port memory between the pipelined CPU's fetch stage (F) and memory stage (M).
- Sequences each access over a req/ack memory handshake and returns read data to the winning requester.
- Emits per-stage stall requests that the hazard unit ORs into StallF/StallD/StallM.
- Fixed priority to M (the older instruction), with a burst limit so F cannot starve.

Parameters:
- AW, 32, address width
- DW, 32, data width
- MAX_D_BURST, 4, max consecutive M grants while IReqF is pending (≥1)

Ports:
- CLK  in  1  clock, rising edge
- nRESET  in  1  asynchronous, active-low reset
- IReqF  in  1  fetch read request, held until IReadyF
- IAddrF  in  AW  fetch address, stable while IReqF
- IRdataF  out  DW  fetch read data, valid when IReadyF
- IReadyF  out  1  one-cycle fetch completion pulse
- DReqM  in  1  data request, held until DReadyM
- DWeM  in  1  1 = write, 0 = read
- DAddrM  in  AW  data address
- DWdataM  in  DW  write data
- DRdataM  out  DW  data read data, valid when DReadyM
- DReadyM  out  1  one-cycle data completion pulse
- MemReq  out  1  memory request, held until MemAck
- MemWe  out  1  memory write enable
- MemAddr  out  AW  memory address
- MemWdata  out  DW  memory write data
- MemRdata  in  DW  memory read data, valid with MemAck
- MemAck  in  1  one-cycle completion, may arrive in the first MemReq cycle or any later cycle
- StallF  out  1  IReqF & ~IReadyF (combinational)
- StallM  out  1  DReqM & ~DReadyM (combinational)
- ErrAck  out  1  sticky: MemAck seen while no access outstanding

Behaviour:
- Reset (async on nRESET=0): state IDLE. All registered outputs are 0: MemReq, MemWe, MemAddr, MemWdata, IRdataF, DRdataF, IReadyF, DReadyM, ErrAck. Burst counter DCnt=0. Reset mid-access abandons the access; a MemAck arriving after reset while in IDLE sets ErrAck.
- States: IDLE, ACC_I, ACC_D, RESP.
- Arbitration runs at the clock edge in IDLE and RESP:
  - DReqM wins unless IReqF=1 and DCnt==MAX_D_BURST, in which case F wins.
  - A requester whose Ready is high in the current cycle is excluded; its Req is stale.
- On grant, the selected request is captured into the registered Mem* outputs, MemReq=1, next state ACC_I or ACC_D.
- DCnt update:
  - Increments on each D grant while IReqF=1, saturating at MAX_D_BURST.
  - Clears on any F grant, or on a D grant with IReqF=0.
- ACC_x: Mem* outputs are held. On MemAck=1 at the edge:
  - MemReq→0.
  - For reads, MemRdata is registered into IRdataF/DRdataM; for writes, the rdata register is unchanged.
  - The matching Ready pulses 1 the next cycle; state→RESP.
- RESP: Ready is high for exactly this cycle. If an eligible request exists, grant it (back-to-back). Otherwise go to IDLE.
- Latency: request seen at edge 0 → MemReq high in cycle 1 → with MemAck in cycle 1, Ready high in cycle 2. Minimum 2 cycles per access; back-to-back throughput is one access per 2 cycles.
- Simultaneous IReqF and DReqM in IDLE: D is granted and F stalls.
- Write-through for stores: DRdataM is undefined-but-stable; it holds its last read value.
- MemAck in IDLE or RESP: ignored for data and sets ErrAck=1 until reset.
- Req dropped before Ready (protocol violation): the access completes anyway and Ready still pulses.

Decomposition:
- Package mem_arb_pkg: state enum arb_state_t {IDLE, ACC_I, ACC_D, RESP}; owner enum {OWN_F, OWN_D}.
- Single module; no sub-module. The burst counter and FSM are small enough to stay inline.

Test Plan:
- Single fetch: IReqF=1, IAddrF=0x100, memory acks in first MemReq cycle with MemRdata=0xE3A01005 → MemReq=1/MemAddr=0x100 in cycle 1, IReadyF=1 with IRdataF=0xE3A01005 in cycle 2; StallF=1 in cycles 0–1.
- Contention: IReqF and DReqM (read 0x200) rise together → D served first (DReadyM), F granted in the RESP cycle, IReadyF 2 cycles later.
- Starvation limit: IReqF held, DReqM continuously reasserted, MAX_D_BURST=4 → exactly 4 D accesses, then F granted, then D resumes.
- Store plus variable latency: DReqM=1, DWeM=1, DAddrM=0x40, DWdataM=0xDEADBEEF, MemAck after 3 wait cycles → MemWe=1 with stable address/data for 4 cycles, DReadyM pulse once, DRdataM unchanged.
- Reset mid-access: nRESET low during ACC_D → immediately MemReq=0 and all outputs 0; later MemAck → ErrAck=1, no Ready pulse.
- Stray ack: MemAck=1 in IDLE with no requests → ErrAck=1 and sticky; IReadyF and DReadyM stay 0.
